mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 95 +++++++++
 tb/tb_mem_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one request per load/store, stalls the
// pipeline while the access is outstanding, and latches sticky alignment/timeout errors.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        readEnM,
   input  logic        memWrtM,
   input  logic [15:0] aluFinalM,
   input  logic [15:0] wrtDataM,
   input  logic        mem_done,
   input  logic        mem_busy,
   input  logic [15:0] mem_rdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        stallM,
   output logic [15:0] rdDataM,
   output logic        accDoneM,
   output logic        errAlign,
   output logic        errTimeout,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       is_load;
   logic       acc;
   logic       issue;

   // Request handshake: the memory accepts a request in any cycle where mem_en=1
   // and mem_busy=0; completion is the single-cycle mem_done strobe, honoured only in WAIT.
   assign acc       = readEnM | memWrtM;
   assign issue     = !rst && (state == IDLE) && acc && !aluFinalM[0] && !mem_busy;
   assign mem_en    = issue;
   assign mem_wr    = memWrtM;
   assign mem_addr  = aluFinalM;
   assign mem_wdata = wrtDataM;
   assign stallM    = !rst && (((state == IDLE) && acc) || (state == WAIT));
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         is_load    <= 1'b0;
         rdDataM    <= 16'h0000;
         accDoneM   <= 1'b0;
         errAlign   <= 1'b0;
         errTimeout <= 1'b0;
      end else begin
         accDoneM <= 1'b0;
         case (state)
            IDLE: begin
               if (acc) begin
                  if (aluFinalM[0]) begin
                     errAlign <= 1'b1;
                     state    <= ERR;
                  end else if (!mem_busy) begin
                     // A simultaneous read+write request is a store.
                     is_load  <= ~memWrtM;
                     wait_cnt <= 4'd0;
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mem_done) begin
                  if (is_load) rdDataM <= mem_rdata;
                  accDoneM <= 1'b1;
                  wait_cnt <= 4'd0;
                  state    <= DONE;
               end else if (wait_cnt == 4'hF) begin
                  errTimeout <= 1'b1;
                  wait_cnt   <= 4'd0;
                  state      <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: state <= IDLE;
            ERR:  state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, store, busy, misalign, timeout and reset cases.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        readEnM;
   logic        memWrtM;
   logic [15:0] aluFinalM;
   logic [15:0] wrtDataM;
   logic        mem_done;
   logic        mem_busy;
   logic [15:0] mem_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        stallM;
   logic [15:0] rdDataM;
   logic        accDoneM;
   logic        errAlign;
   logic        errTimeout;
   logic [1:0]  dbg_state;

   int vectors;
   int miscompares;

   mem_access_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .readEnM    (readEnM),
      .memWrtM    (memWrtM),
      .aluFinalM  (aluFinalM),
      .wrtDataM   (wrtDataM),
      .mem_done   (mem_done),
      .mem_busy   (mem_busy),
      .mem_rdata  (mem_rdata),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .stallM     (stallM),
      .rdDataM    (rdDataM),
      .accDoneM   (accDoneM),
      .errAlign   (errAlign),
      .errTimeout (errTimeout),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst       = 1'b1;
      readEnM   = 1'b0;
      memWrtM   = 1'b0;
      aluFinalM = 16'h0000;
      wrtDataM  = 16'h0000;
      mem_done  = 1'b0;
      mem_busy  = 1'b0;
      mem_rdata = 16'h0000;
      tick();
      tick();

      // reset state, and no request/stall while rst is held even with acc=1
      chk("rst_rdData", rdDataM, 16'h0000);
      chk("rst_accDone", {15'd0, accDoneM}, 16'd0);
      chk("rst_errAlign", {15'd0, errAlign}, 16'd0);
      chk("rst_errTimeout", {15'd0, errTimeout}, 16'd0);
      chk("rst_state", {14'd0, dbg_state}, 16'd0);
      readEnM = 1'b1;
      #1;
      chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
      chk("rst_stall", {15'd0, stallM}, 16'd0);
      readEnM = 1'b0;
      rst     = 1'b0;
      tick();
      chk("idle_stall", {15'd0, stallM}, 16'd0);

      // load, mem_done three cycles after mem_en
      readEnM   = 1'b1;
      aluFinalM = 16'h0010;
      wrtDataM  = 16'h5555;
      #1;
      chk("ld_mem_en", {15'd0, mem_en}, 16'd1);
      chk("ld_mem_wr", {15'd0, mem_wr}, 16'd0);
      chk("ld_addr", mem_addr, 16'h0010);
      chk("ld_wdata_pass", mem_wdata, 16'h5555);
      chk("ld_stall0", {15'd0, stallM}, 16'd1);
      tick();
      chk("ld_state_wait", {14'd0, dbg_state}, 16'd1);
      chk("ld_mem_en1", {15'd0, mem_en}, 16'd0);
      chk("ld_stall1", {15'd0, stallM}, 16'd1);
      tick();
      chk("ld_mem_en2", {15'd0, mem_en}, 16'd0);
      chk("ld_stall2", {15'd0, stallM}, 16'd1);
      tick();
      mem_done  = 1'b1;
      mem_rdata = 16'hBEEF;
      #1;
      chk("ld_mem_en3", {15'd0, mem_en}, 16'd0);
      chk("ld_stall3", {15'd0, stallM}, 16'd1);
      tick();
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
      #1;
      chk("ld_accDone", {15'd0, accDoneM}, 16'd1);
      chk("ld_done_stall", {15'd0, stallM}, 16'd0);
      chk("ld_done_no_issue", {15'd0, mem_en}, 16'd0);
      chk("ld_rdData", rdDataM, 16'hBEEF);
      readEnM = 1'b0;
      tick();
      chk("ld_accDone_clr", {15'd0, accDoneM}, 16'd0);
      chk("ld_back_idle", {14'd0, dbg_state}, 16'd0);

      // store with both request bits set
      readEnM   = 1'b1;
      memWrtM   = 1'b1;
      aluFinalM = 16'h0020;
      wrtDataM  = 16'h1234;
      #1;
      chk("st_mem_en", {15'd0, mem_en}, 16'd1);
      chk("st_mem_wr", {15'd0, mem_wr}, 16'd1);
      chk("st_wdata", mem_wdata, 16'h1234);
      chk("st_addr", mem_addr, 16'h0020);
      tick();
      mem_done  = 1'b1;
      mem_rdata = 16'hAAAA;
      tick();
      mem_done  = 1'b0;
      chk("st_accDone", {15'd0, accDoneM}, 16'd1);
      chk("st_rdData_kept", rdDataM, 16'hBEEF);
      readEnM = 1'b0;
      memWrtM = 1'b0;
      tick();

      // busy for five cycles, then issue on the first free cycle
      readEnM   = 1'b1;
      aluFinalM = 16'h0030;
      mem_busy  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("busy_mem_en", {15'd0, mem_en}, 16'd0);
         chk("busy_stall", {15'd0, stallM}, 16'd1);
         tick();
      end
      chk("busy_state_idle", {14'd0, dbg_state}, 16'd0);
      mem_busy = 1'b0;
      #1;
      chk("busy_release_en", {15'd0, mem_en}, 16'd1);
      tick();
      mem_done  = 1'b1;
      mem_rdata = 16'h0042;
      tick();
      mem_done = 1'b0;
      readEnM  = 1'b0;
      chk("busy_accDone", {15'd0, accDoneM}, 16'd1);
      chk("busy_rdData", rdDataM, 16'h0042);
      tick();

      // stray mem_done in IDLE is ignored
      mem_done  = 1'b1;
      mem_rdata = 16'hFFFF;
      tick();
      mem_done = 1'b0;
      chk("stray_rdData", rdDataM, 16'h0042);
      chk("stray_accDone", {15'd0, accDoneM}, 16'd0);
      chk("stray_state", {14'd0, dbg_state}, 16'd0);

      // timeout: mem_done never comes
      readEnM   = 1'b1;
      aluFinalM = 16'h0040;
      tick();
      for (int i = 0; i < 15; i++) begin
         chk("to_pending", {15'd0, errTimeout}, 16'd0);
         tick();
      end
      chk("to_last_stall", {15'd0, stallM}, 16'd1);
      chk("to_last_state", {14'd0, dbg_state}, 16'd1);
      tick();
      chk("to_errTimeout", {15'd0, errTimeout}, 16'd1);
      chk("to_state_err", {14'd0, dbg_state}, 16'd3);
      chk("to_err_stall", {15'd0, stallM}, 16'd0);
      chk("to_err_no_en", {15'd0, mem_en}, 16'd0);
      tick();
      chk("to_sticky", {15'd0, errTimeout}, 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("to_rst_clear", {15'd0, errTimeout}, 16'd0);

      // mem_done arriving together with wait_cnt=15 completes normally
      tick();
      for (int i = 0; i < 15; i++) tick();
      mem_done  = 1'b1;
      mem_rdata = 16'h7777;
      tick();
      mem_done = 1'b0;
      readEnM  = 1'b0;
      chk("edge_accDone", {15'd0, accDoneM}, 16'd1);
      chk("edge_no_timeout", {15'd0, errTimeout}, 16'd0);
      chk("edge_rdData", rdDataM, 16'h7777);
      tick();

      // reset during WAIT, then a late mem_done
      readEnM   = 1'b1;
      aluFinalM = 16'h0050;
      tick();
      chk("rw_in_wait", {14'd0, dbg_state}, 16'd1);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      readEnM   = 1'b0;
      mem_done  = 1'b1;
      mem_rdata = 16'h9999;
      tick();
      mem_done = 1'b0;
      chk("rw_state_idle", {14'd0, dbg_state}, 16'd0);
      chk("rw_no_accDone", {15'd0, accDoneM}, 16'd0);
      chk("rw_rdData", rdDataM, 16'h0000);

      // misaligned access: sticky error, later accesses ignored
      readEnM   = 1'b1;
      aluFinalM = 16'h0011;
      #1;
      chk("mis_no_en", {15'd0, mem_en}, 16'd0);
      chk("mis_stall_idle", {15'd0, stallM}, 16'd1);
      tick();
      chk("mis_errAlign", {15'd0, errAlign}, 16'd1);
      chk("mis_err_stall", {15'd0, stallM}, 16'd0);
      aluFinalM = 16'h0012;
      #1;
      chk("mis_later_no_en", {15'd0, mem_en}, 16'd0);
      tick();
      tick();
      chk("mis_sticky", {15'd0, errAlign}, 16'd1);
      chk("mis_state_err", {14'd0, dbg_state}, 16'd3);
      rst     = 1'b1;
      readEnM = 1'b0;
      tick();
      rst = 1'b0;
      chk("mis_rst_clear", {15'd0, errAlign}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
